// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
// Contents: source-select enum, RD_ZERO, wait-counter width.
package wb_pkg;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_LSU,
        SRC_MDU
    } src_t;

    localparam int RD_ZERO = 0;
    localparam int WAIT_W  = 4;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination bit vector; a set beats a clear on the same index.
// Ports: i_clock, i_reset, i_set/i_set_rd, i_clr/i_clr_rd, o_busy[NUM].
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int NUM = 32,
    parameter int AW  = $clog2(NUM)
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           i_set,
    input  logic [AW-1:0]  i_set_rd,
    input  logic           i_clr,
    input  logic [AW-1:0]  i_clr_rd,
    output logic [NUM-1:0] o_busy
);

    logic [NUM-1:0] r_busy;
    logic [NUM-1:0] w_next;

    always_comb begin
        w_next = r_busy;
        if (i_clr) w_next[i_clr_rd] = 1'b0;
        // Set after clear so a reissue to the same register stays pending.
        if (i_set) w_next[i_set_rd] = 1'b1;
        w_next[RD_ZERO] = 1'b0;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) r_busy <= '0;
        else         r_busy <= w_next;
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU/LSU/MDU results onto one register-file write port.
// Ports: clock, reset, {alu,lsu,mdu}_{valid,ready,rd,data}, issue_valid,
// issue_rd, addr_w/data_w (registered, addr 0 = no write), busy[NUM].
// Optional scoreboard: define WB_SCOREBOARD_EN; otherwise busy is 0.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM      = 32,
    parameter int MAX_WAIT = 4,
    localparam int AW      = $clog2(NUM)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            mdu_valid,
    output logic            mdu_ready,
    input  logic [AW-1:0]   mdu_rd,
    input  logic [XLEN-1:0] mdu_data,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic [AW-1:0]   addr_w,
    output logic [XLEN-1:0] data_w,
    output logic [NUM-1:0]  busy
);

    localparam logic [WAIT_W-1:0] W_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [AW-1:0]     W_ZERO = AW'(RD_ZERO);

    logic [WAIT_W-1:0] r_lsu_wait;
    logic [WAIT_W-1:0] r_mdu_wait;
    logic [AW-1:0]     r_addr;
    logic [XLEN-1:0]   r_data;

    logic            w_lsu_aged;
    logic            w_mdu_aged;
    logic            w_alu_xfer;
    logic            w_lsu_xfer;
    logic            w_mdu_xfer;
    src_t            w_src;
    logic [AW-1:0]   w_rd;
    logic [XLEN-1:0] w_data;

    assign w_lsu_aged = (r_lsu_wait == W_MAX);
    assign w_mdu_aged = (r_mdu_wait == W_MAX);

    // Each ready is "this source would win if it were valid", so it
    // never looks at its own valid.
    assign alu_ready = !reset && !w_lsu_aged && !w_mdu_aged;
    assign lsu_ready = !reset
                     && (w_lsu_aged || (!w_mdu_aged && !alu_valid));
    assign mdu_ready = !reset && !w_lsu_aged
                     && (w_mdu_aged || (!alu_valid && !lsu_valid));

    assign w_alu_xfer = alu_valid && alu_ready;
    assign w_lsu_xfer = lsu_valid && lsu_ready;
    assign w_mdu_xfer = mdu_valid && mdu_ready;

    // The ready equations make the three transfers mutually exclusive.
    always_comb begin
        w_src  = SRC_NONE;
        w_rd   = W_ZERO;
        w_data = '0;
        unique case (1'b1)
            w_alu_xfer: begin
                w_src  = SRC_ALU;
                w_rd   = alu_rd;
                w_data = alu_data;
            end
            w_lsu_xfer: begin
                w_src  = SRC_LSU;
                w_rd   = lsu_rd;
                w_data = lsu_data;
            end
            w_mdu_xfer: begin
                w_src  = SRC_MDU;
                w_rd   = mdu_rd;
                w_data = mdu_data;
            end
            default: ;
        endcase
    end

    function automatic logic [WAIT_W-1:0] next_wait(
        input logic              v,
        input logic              xfer,
        input logic [WAIT_W-1:0] cnt
    );
        if (!v || xfer)      return '0;
        else if (cnt == W_MAX) return cnt;
        else                 return cnt + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lsu_wait <= '0;
            r_mdu_wait <= '0;
            r_addr     <= W_ZERO;
            r_data     <= '0;
        end else begin
            r_lsu_wait <= next_wait(lsu_valid, w_lsu_xfer, r_lsu_wait);
            r_mdu_wait <= next_wait(mdu_valid, w_mdu_xfer, r_mdu_wait);
            r_addr     <= (w_src != SRC_NONE) ? w_rd : W_ZERO;
            if (w_src != SRC_NONE) r_data <= w_data;
        end
    end

    assign addr_w = r_addr;
    assign data_w = r_data;

`ifdef WB_SCOREBOARD_EN
    wb_scoreboard #(
        .NUM (NUM),
        .AW  (AW)
    ) u_sb (
        .i_clock  (clock),
        .i_reset  (reset),
        .i_set    (issue_valid && (issue_rd != W_ZERO)),
        .i_set_rd (issue_rd),
        .i_clr    ((w_src == SRC_LSU) || (w_src == SRC_MDU)),
        .i_clr_rd (w_rd),
        .o_busy   (busy)
    );
`else
    logic w_unused;
    assign w_unused = ^{issue_valid, issue_rd};
    assign busy     = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a priority/aging reference model.
module tb_wb_arbiter;

    localparam int XLEN = 32;
    localparam int NUM  = 32;
    localparam int AW   = 5;
    localparam int MAXW = 4;
    localparam int S_NONE = 0;
    localparam int S_ALU  = 1;
    localparam int S_LSU  = 2;
    localparam int S_MDU  = 3;
`ifdef WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic            alu_valid, alu_ready;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid, lsu_ready;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            mdu_valid, mdu_ready;
    logic [AW-1:0]   mdu_rd;
    logic [XLEN-1:0] mdu_data;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic [AW-1:0]   addr_w;
    logic [XLEN-1:0] data_w;
    logic [NUM-1:0]  busy;

    wb_arbiter #(
        .XLEN     (XLEN),
        .NUM      (NUM),
        .MAX_WAIT (MAXW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .mdu_valid   (mdu_valid),
        .mdu_ready   (mdu_ready),
        .mdu_rd      (mdu_rd),
        .mdu_data    (mdu_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .addr_w      (addr_w),
        .data_w      (data_w),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: priority list with refused-cycle ages.
    function automatic int winner(input bit av, input bit lv, input bit mv,
                                  input int la, input int ma);
        if (la == MAXW) return S_LSU;
        if (ma == MAXW) return S_MDU;
        if (av)         return S_ALU;
        if (lv)         return S_LSU;
        if (mv)         return S_MDU;
        return S_NONE;
    endfunction

    int              m_la, m_ma, g;
    bit              m_known = 1'b0;
    bit              er, el, em;
    logic [AW-1:0]   m_addr;
    logic [XLEN-1:0] m_data;
    logic [NUM-1:0]  m_busy;

    always @(negedge clock) begin
        if (reset) begin
            er = 0; el = 0; em = 0; g = S_NONE;
        end else begin
            er = winner(1'b1, lsu_valid, mdu_valid, m_la, m_ma) == S_ALU;
            el = winner(alu_valid, 1'b1, mdu_valid, m_la, m_ma) == S_LSU;
            em = winner(alu_valid, lsu_valid, 1'b1, m_la, m_ma) == S_MDU;
            g  = winner(alu_valid, lsu_valid, mdu_valid, m_la, m_ma);
        end
        if (m_known) begin
            chk("m_alu_ready", 64'(alu_ready), 64'(er));
            chk("m_lsu_ready", 64'(lsu_ready), 64'(el));
            chk("m_mdu_ready", 64'(mdu_ready), 64'(em));
            chk("m_addr_w", 64'(addr_w), 64'(m_addr));
            chk("m_data_w", 64'(data_w), 64'(m_data));
            chk("m_busy", 64'(busy), 64'(m_busy));
        end
        if (reset) begin
            m_la = 0; m_ma = 0; m_addr = '0; m_data = '0; m_busy = '0;
            m_known = 1'b1;
        end else if (m_known) begin
            m_addr = '0;
            if (g == S_ALU) begin m_addr = alu_rd; m_data = alu_data; end
            if (g == S_LSU) begin m_addr = lsu_rd; m_data = lsu_data; end
            if (g == S_MDU) begin m_addr = mdu_rd; m_data = mdu_data; end
            m_la = (lsu_valid && g != S_LSU) ? ((m_la < MAXW) ? m_la + 1 : MAXW) : 0;
            m_ma = (mdu_valid && g != S_MDU) ? ((m_ma < MAXW) ? m_ma + 1 : MAXW) : 0;
            if (SB) begin
                if (g == S_LSU) m_busy[lsu_rd] = 1'b0;
                if (g == S_MDU) m_busy[mdu_rd] = 1'b0;
                if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
                m_busy[0] = 1'b0;
            end
        end
    end

    task automatic cyc(); @(posedge clock); #1; endtask
    task automatic smp(); @(negedge clock); #1; endtask
    task automatic idle();
        alu_valid = 0; lsu_valid = 0; mdu_valid = 0; issue_valid = 0;
    endtask

    bit ta, tl, tm;
    int pa;

    initial begin
        reset = 1; idle();
        alu_rd = 3; alu_data = 0; lsu_rd = 0; lsu_data = 0;
        mdu_rd = 0; mdu_data = 0; issue_rd = 0;
        alu_valid = 1; lsu_valid = 1;
        smp();
        chk("rst_alu_ready", 64'(alu_ready), 0);
        chk("rst_lsu_ready", 64'(lsu_ready), 0);
        cyc(); smp();
        chk("rst_addr_w", 64'(addr_w), 0);
        chk("rst_data_w", 64'(data_w), 0);
        chk("rst_busy", 64'(busy), 0);
        cyc(); reset = 0; idle();

        // single ALU write
        alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
        smp(); chk("alu1_ready", 64'(alu_ready), 1);
        cyc(); idle();
        smp();
        chk("alu1_addr", 64'(addr_w), 5);
        chk("alu1_data", 64'(data_w), 64'h1234);
        cyc(); smp();
        chk("alu1_addr_clr", 64'(addr_w), 0);
        cyc();

        // starvation: LSU rd=7 behind a stuck ALU
        alu_valid = 1; alu_rd = 1; alu_data = 1;
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'hABCD;
        for (int k = 1; k <= 5; k++) begin
            smp();
            chk($sformatf("starve_lsu_rdy%0d", k), 64'(lsu_ready), 64'(k == 5));
            chk($sformatf("starve_alu_rdy%0d", k), 64'(alu_ready), 64'(k != 5));
            cyc();
            if (k < 5) begin alu_rd = AW'(k + 1); alu_data = 32'(k + 1); end
        end
        lsu_valid = 0;
        smp();
        chk("starve_addr", 64'(addr_w), 7);
        chk("starve_data", 64'(data_w), 64'hABCD);
        cyc(); idle();
        smp(); chk("starve_alu_after", 64'(addr_w), 5);
        cyc();

        // rd=0 result is accepted but never written
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hFFFF;
        smp(); chk("rd0_ready", 64'(lsu_ready), 1);
        cyc(); idle();
        smp(); chk("rd0_addr", 64'(addr_w), 0);
        cyc();

        // contention
        alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
        lsu_valid = 1; lsu_rd = 2; lsu_data = 32'h22;
        mdu_valid = 1; mdu_rd = 3; mdu_data = 32'h33;
        smp();
        chk("cont_alu_rdy", 64'(alu_ready), 1);
        chk("cont_lsu_rdy0", 64'(lsu_ready), 0);
        cyc(); alu_valid = 0;
        smp();
        chk("cont_addr1", 64'(addr_w), 1);
        chk("cont_lsu_rdy", 64'(lsu_ready), 1);
        chk("cont_mdu_rdy0", 64'(mdu_ready), 0);
        cyc(); lsu_valid = 0;
        smp();
        chk("cont_addr2", 64'(addr_w), 2);
        chk("cont_mdu_rdy", 64'(mdu_ready), 1);
        cyc(); mdu_valid = 0;
        smp();
        chk("cont_addr3", 64'(addr_w), 3);
        chk("cont_data3", 64'(data_w), 64'h33);
        cyc(); smp();
        chk("cont_addr_idle", 64'(addr_w), 0);
        cyc();

        // scoreboard
        issue_valid = 1; issue_rd = 9;
        cyc(); issue_valid = 0;
        smp(); chk("sb_set9", 64'(busy), SB ? 64'h200 : 0);
        cyc();
        mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h99;
        issue_valid = 1; issue_rd = 9;
        smp(); chk("sb_mdu_rdy", 64'(mdu_ready), 1);
        cyc(); idle();
        smp(); chk("sb_set_wins", 64'(busy), SB ? 64'h200 : 0);
        cyc();
        mdu_valid = 1;
        cyc(); idle();
        smp(); chk("sb_clear9", 64'(busy), 0);
        cyc();
        issue_valid = 1; issue_rd = 0;
        cyc(); idle();
        smp(); chk("sb_rd0", 64'(busy), 0);
        cyc();

        // reset in the cycle after a grant, with LSU fully aged
        issue_valid = 1; issue_rd = 12;
        alu_valid = 1; alu_rd = 6; alu_data = 32'h66;
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h77;
        for (int k = 1; k <= 4; k++) begin
            smp();
            chk($sformatf("mid_alu_rdy%0d", k), 64'(alu_ready), 1);
            cyc(); issue_valid = 0;
        end
        reset = 1;
        smp();
        chk("mid_rst_alu_rdy", 64'(alu_ready), 0);
        chk("mid_rst_lsu_rdy", 64'(lsu_ready), 0);
        chk("mid_rst_addr_pre", 64'(addr_w), 6);
        cyc(); reset = 0;
        smp();
        chk("mid_addr", 64'(addr_w), 0);
        chk("mid_data", 64'(data_w), 0);
        chk("mid_busy", 64'(busy), 0);
        chk("mid_alu_rdy", 64'(alu_ready), 1);
        chk("mid_lsu_rdy", 64'(lsu_ready), 0);
        cyc(); alu_valid = 0;
        smp();
        chk("mid_addr_alu", 64'(addr_w), 6);
        chk("mid_lsu_rdy2", 64'(lsu_ready), 1);
        cyc(); idle();
        smp(); chk("mid_addr_lsu", 64'(addr_w), 7);
        cyc();

        // randomized traffic; the model process checks every cycle
        for (int c = 0; c < 3000; c++) begin
            smp();
            ta = alu_valid && alu_ready;
            tl = lsu_valid && lsu_ready;
            tm = mdu_valid && mdu_ready;
            cyc();
            pa = ((c / 500) % 2 == 1) ? 10 : 5;
            reset = ($urandom_range(0, 149) == 0);
            if (!alu_valid || ta) begin
                alu_valid = ($urandom_range(0, 9) < pa);
                alu_rd = AW'($urandom); alu_data = $urandom;
            end
            if (!lsu_valid || tl) begin
                lsu_valid = ($urandom_range(0, 9) < 5);
                lsu_rd = AW'($urandom); lsu_data = $urandom;
            end
            if (!mdu_valid || tm) begin
                mdu_valid = ($urandom_range(0, 9) < 4);
                mdu_rd = AW'($urandom); mdu_data = $urandom;
            end
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_rd = AW'($urandom);
        end
        reset = 0; idle();
        cyc(); smp();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
